lockin_iq: RTL and testbench

LOCKIN_IQ -- requirements
Module: lockin_iq

---
 rtl/lockin_iq.sv | 214 +++++++++++++++++++++
 tb/tb_lockin_iq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockin_iq.sv
// lockin_iq: dual-phase (I/Q) lock-in integrator.
//
// Each accepted sample is multiplied by the in-phase and quadrature references. The products
// are summed over a window of 2^win_log2 accepted samples, and then dumped as
// (sum >>> (win_log2 + OUT_SHIFT)), saturated to OW bits. Windows follow each other with no
// gap: the product after a dump starts the next window.
//
// Optional feature (macro LOCKIN_IQ_AVG_EN): each dump result passes through a
// 2^AVG_LOG2-deep boxcar average per channel. This adds one cycle of latency.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   qualifies signal_in / ref_i / ref_q
//   signal_in  in   DW-bit signed sample
//   ref_i      in   RW-bit signed in-phase reference
//   ref_q      in   RW-bit signed quadrature reference
//   win_log2   in   window exponent; latched at window start, clamped to MAX_WIN_LOG2
//   clear      in   synchronous restart (drops partial window and in-flight product)
//   out_i      out  OW-bit signed in-phase result, held between strobes
//   out_q      out  OW-bit signed quadrature result, held between strobes
//   out_valid  out  one-cycle strobe per new result
//   overflow   out  sticky saturation flag, cleared by rst or clear
module lockin_iq #(
    parameter int unsigned DW           = 14,
    parameter int unsigned RW           = 16,
    parameter int unsigned OW           = 24,
    parameter int unsigned MAX_WIN_LOG2 = 20,
    parameter int unsigned OUT_SHIFT    = 6,
    parameter int unsigned AVG_LOG2     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] signal_in,
    input  logic signed [RW-1:0] ref_i,
    input  logic signed [RW-1:0] ref_q,
    input  logic [4:0]           win_log2,
    input  logic                 clear,
    output logic signed [OW-1:0] out_i,
    output logic signed [OW-1:0] out_q,
    output logic                 out_valid,
    output logic                 overflow
);

    localparam int unsigned PW = DW + RW;
    localparam int unsigned AW = PW + MAX_WIN_LOG2;
    localparam int unsigned CW = MAX_WIN_LOG2 + 1;
    localparam logic [4:0]  MaxWin = 5'(MAX_WIN_LOG2);
    localparam logic signed [AW-1:0] SatMax = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic {StIdle, StAcc} state_e;

    // Stage 1: product registers
    logic signed [PW-1:0] prod_i_q, prod_q_q;
    logic                 prod_v_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_i_q <= '0;
            prod_q_q <= '0;
            prod_v_q <= 1'b0;
        end else begin
            // A sample arriving together with clear is dropped.
            prod_v_q <= in_valid & ~clear;
            if (in_valid) begin
                prod_i_q <= signal_in * ref_i;
                prod_q_q <= signal_in * ref_q;
            end
        end
    end

    // Stage 2: windowed accumulation and dump
    state_e               state_q, state_d;
    logic [4:0]           win_q, win_cur;
    logic [CW-1:0]        cnt_q, win_mask;
    logic signed [AW-1:0] acc_i_q, acc_q_q, sum_i, sum_q, sh_i, sh_q;
    logic [5:0]           shamt;
    logic                 last, ovf_i, ovf_q;
    logic signed [OW-1:0] sat_i, sat_q, res_i_q, res_q_q;
    logic                 res_v_q;

    always_comb begin
        // In StIdle the product opens a new window, so it uses the live win_log2.
        win_cur = win_q;
        if (state_q == StIdle) begin
            win_cur = (win_log2 > MaxWin) ? MaxWin : win_log2;
        end
        // Accumulators and counter are zero whenever the state is StIdle.
        sum_i    = acc_i_q + AW'(prod_i_q);
        sum_q    = acc_q_q + AW'(prod_q_q);
        win_mask = (CW'(1) << win_cur) - CW'(1);
        last     = (cnt_q == win_mask);
        shamt    = 6'(win_cur) + 6'(OUT_SHIFT);
        sh_i     = sum_i >>> shamt;
        sh_q     = sum_q >>> shamt;
        ovf_i    = (sh_i > SatMax) || (sh_i < SatMin);
        ovf_q    = (sh_q > SatMax) || (sh_q < SatMin);
        sat_i    = sh_i[OW-1:0];
        sat_q    = sh_q[OW-1:0];
        if (sh_i > SatMax) sat_i = SatMax[OW-1:0];
        if (sh_i < SatMin) sat_i = SatMin[OW-1:0];
        if (sh_q > SatMax) sat_q = SatMax[OW-1:0];
        if (sh_q < SatMin) sat_q = SatMin[OW-1:0];

        // A dump returns to StIdle so the next product latches a fresh window size.
        state_d = state_q;
        if (prod_v_q) begin
            state_d = last ? StIdle : StAcc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            win_q    <= '0;
            cnt_q    <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            res_i_q  <= '0;
            res_q_q  <= '0;
            res_v_q  <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            res_v_q  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            res_v_q <= prod_v_q & last;
            if (prod_v_q) begin
                if (state_q == StIdle) win_q <= win_cur;
                if (last) begin
                    cnt_q   <= '0;
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                    res_i_q <= sat_i;
                    res_q_q <= sat_q;
                    if (ovf_i || ovf_q) overflow <= 1'b1;
                end else begin
                    cnt_q   <= cnt_q + CW'(1);
                    acc_i_q <= sum_i;
                    acc_q_q <= sum_q;
                end
            end
        end
    end

`ifdef LOCKIN_IQ_AVG_EN
    // Boxcar over the last 2^AVG_LOG2 dump results; history starts at zero so outputs ramp.
    localparam int unsigned AN = 1 << AVG_LOG2;
    localparam int unsigned SW = OW + AVG_LOG2;

    logic signed [OW-1:0] hist_i_q [AN];
    logic signed [OW-1:0] hist_q_q [AN];
    logic signed [SW-1:0] asum_i_q, asum_q_q, asum_i_d, asum_q_d;
    logic signed [OW-1:0] avg_i_q, avg_q_q;
    logic                 avg_v_q;

    always_comb begin
        asum_i_d = asum_i_q + SW'(res_i_q) - SW'(hist_i_q[AN-1]);
        asum_q_d = asum_q_q + SW'(res_q_q) - SW'(hist_q_q[AN-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < AN; k++) begin
                hist_i_q[k] <= '0;
                hist_q_q[k] <= '0;
            end
            asum_i_q <= '0;
            asum_q_q <= '0;
            avg_i_q  <= '0;
            avg_q_q  <= '0;
            avg_v_q  <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < AN; k++) begin
                hist_i_q[k] <= '0;
                hist_q_q[k] <= '0;
            end
            asum_i_q <= '0;
            asum_q_q <= '0;
            avg_v_q  <= 1'b0;
        end else begin
            avg_v_q <= res_v_q;
            if (res_v_q) begin
                for (int k = AN - 1; k > 0; k--) begin
                    hist_i_q[k] <= hist_i_q[k-1];
                    hist_q_q[k] <= hist_q_q[k-1];
                end
                hist_i_q[0] <= res_i_q;
                hist_q_q[0] <= res_q_q;
                asum_i_q    <= asum_i_d;
                asum_q_q    <= asum_q_d;
                avg_i_q     <= OW'(asum_i_d >>> AVG_LOG2);
                avg_q_q     <= OW'(asum_q_d >>> AVG_LOG2);
            end
        end
    end

    assign out_i     = avg_i_q;
    assign out_q     = avg_q_q;
    assign out_valid = avg_v_q;
`else
    assign out_i     = res_i_q;
    assign out_q     = res_q_q;
    assign out_valid = res_v_q;
`endif

endmodule

// File: tb/tb_lockin_iq.sv
// Self-checking bench for lockin_iq. A sample-level model (window lists summed with 64-bit
// arithmetic) predicts every output cycle. A second instance with OUT_SHIFT=0 is used
// for the saturation cases, because the default scaling cannot reach full scale.
module tb_lockin_iq;
    localparam int DW  = 14;
    localparam int RW  = 16;
    localparam int OW  = 24;
    localparam int MW  = 20;
    localparam int OSH = 6;
    localparam int AL  = 2;
`ifdef LOCKIN_IQ_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    localparam int LAT = AVG ? 1 : 0;

    logic clk = 1'b0;
    logic rst, in_valid, clear;
    logic signed [DW-1:0] signal_in;
    logic signed [RW-1:0] ref_i, ref_q;
    logic [4:0] win_log2;
    logic signed [OW-1:0] out_i, out_q, sat_out_i, sat_out_q;
    logic out_valid, overflow, sat_out_valid, sat_overflow;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lockin_iq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signal_in(signal_in), .ref_i(ref_i),
        .ref_q(ref_q), .win_log2(win_log2), .clear(clear), .out_i(out_i), .out_q(out_q),
        .out_valid(out_valid), .overflow(overflow)
    );

    lockin_iq #(.OUT_SHIFT(0)) sat_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signal_in(signal_in), .ref_i(ref_i),
        .ref_q(ref_q), .win_log2(win_log2), .clear(clear), .out_i(sat_out_i),
        .out_q(sat_out_q), .out_valid(sat_out_valid), .overflow(sat_overflow)
    );

    // Reference model state
    bit     m_in_win, m_pend_v, m_v, m_ov, m_stage_v;
    int     m_w, m_cnt;
    longint m_si, m_sq, m_pi, m_pq, m_out_i, m_out_q, m_stage_i, m_stage_q;
    longint m_hi [4];
    longint m_hq [4];

    function automatic longint sat(input longint x);
        longint hi, lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_reset();
        m_in_win = 0; m_pend_v = 0; m_v = 0; m_ov = 0; m_stage_v = 0;
        m_w = 0; m_cnt = 0; m_si = 0; m_sq = 0; m_pi = 0; m_pq = 0;
        m_out_i = 0; m_out_q = 0; m_stage_i = 0; m_stage_q = 0;
        for (int k = 0; k < 4; k++) begin m_hi[k] = 0; m_hq[k] = 0; end
    endtask

    // Drive one cycle of inputs, advance the model, and move to just after the clock edge.
    task automatic step(input bit v, input int s, input int ri, input int rq, input int w,
                        input bit clr);
        bit     dv;
        longint di, dq, full_i, full_q;
        in_valid  = v;
        signal_in = s[DW-1:0];
        ref_i     = ri[RW-1:0];
        ref_q     = rq[RW-1:0];
        win_log2  = w[4:0];
        clear     = clr;
        dv = 0; di = 0; dq = 0;
        if (clr) begin
            m_in_win = 0; m_pend_v = 0; m_v = 0; m_ov = 0; m_stage_v = 0;
            for (int k = 0; k < 4; k++) begin m_hi[k] = 0; m_hq[k] = 0; end
        end else begin
            if (m_pend_v) begin
                if (!m_in_win) begin
                    m_w = (w > MW) ? MW : w;
                    m_in_win = 1; m_cnt = 0; m_si = 0; m_sq = 0;
                end
                m_si += m_pi; m_sq += m_pq; m_cnt++;
                if (m_cnt == (1 << m_w)) begin
                    full_i = m_si >>> (m_w + OSH);
                    full_q = m_sq >>> (m_w + OSH);
                    di = sat(full_i); dq = sat(full_q); dv = 1;
                    if (di != full_i || dq != full_q) m_ov = 1;
                    m_in_win = 0;
                end
            end
            if (AVG) begin
                m_v = m_stage_v;
                if (m_stage_v) begin
                    for (int k = 3; k > 0; k--) begin m_hi[k] = m_hi[k-1]; m_hq[k] = m_hq[k-1]; end
                    m_hi[0] = m_stage_i; m_hq[0] = m_stage_q;
                    m_out_i = (m_hi[0] + m_hi[1] + m_hi[2] + m_hi[3]) >>> AL;
                    m_out_q = (m_hq[0] + m_hq[1] + m_hq[2] + m_hq[3]) >>> AL;
                end
                m_stage_v = dv; m_stage_i = di; m_stage_q = dq;
            end else begin
                m_v = dv;
                if (dv) begin m_out_i = di; m_out_q = dq; end
            end
            m_pend_v = v;
            m_pi = longint'(s) * longint'(ri);
            m_pq = longint'(s) * longint'(rq);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; clear = 0; signal_in = '0; ref_i = '0; ref_q = '0;
        win_log2 = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, overflow, out_i, out_q, sat_out_i} !== {1'b0, 1'b0, 72'd0}) begin
            errors++;
            $display("FAIL reset: got v=%0b ov=%0b i=%0d q=%0d, want all zero",
                     out_valid, overflow, out_i, out_q);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        for (int k = 0; k < 40; k++) begin
            step(1, 1000, 16384, 0, 4, 0);
            vectors++;
            if ({out_valid, overflow, out_i, out_q} !==
                {m_v, m_ov, m_out_i[OW-1:0], m_out_q[OW-1:0]}) begin
                errors++;
                $display("FAIL basic[%0d]: got v=%0b ov=%0b i=%0d q=%0d, want v=%0b ov=%0b i=%0d q=%0d",
                         k, out_valid, overflow, out_i, out_q, m_v, m_ov, m_out_i, m_out_q);
            end
            if (k == 16 + LAT || k == 32 + LAT) begin
                vectors++;
                if (!(out_valid === 1'b1 && out_i === OW'(AVG ? 64000 * (k / 16) : 256000)
                      && out_q === '0)) begin
                    errors++;
                    $display("FAIL basic_strobe[%0d]: got v=%0b i=%0d q=%0d, want v=1 i=%0d q=0",
                             k, out_valid, out_i, out_q, AVG ? 64000 * (k / 16) : 256000);
                end
            end
        end
    endtask

    task automatic test_toggle();
        step(0, 0, 0, 0, 2, 1);
        for (int k = 0; k < 24; k++) begin
            step((k % 2) == 0, 1000, 16384, 0, 2, 0);
            vectors++;
            if ({out_valid, overflow, out_i, out_q} !==
                {m_v, m_ov, m_out_i[OW-1:0], m_out_q[OW-1:0]}) begin
                errors++;
                $display("FAIL toggle[%0d]: got v=%0b ov=%0b i=%0d q=%0d, want v=%0b ov=%0b i=%0d q=%0d",
                         k, out_valid, overflow, out_i, out_q, m_v, m_ov, m_out_i, m_out_q);
            end
            if (k == 7 + LAT) begin
                vectors++;
                if (!(out_valid === 1'b1 && out_i === OW'(AVG ? 64000 : 256000))) begin
                    errors++;
                    $display("FAIL toggle_strobe: got v=%0b i=%0d, want v=1 i=%0d",
                             out_valid, out_i, AVG ? 64000 : 256000);
                end
            end
        end
    endtask

    task automatic test_clear_mid();
        step(0, 0, 0, 0, 4, 1);
        for (int k = 0; k < 12; k++) begin
            step(k < 10, 500, 16384, -16384, 4, k == 11);
            vectors++;
            if ({out_valid, overflow, out_i, out_q} !==
                {m_v, m_ov, m_out_i[OW-1:0], m_out_q[OW-1:0]}) begin
                errors++;
                $display("FAIL clear_mid[%0d]: got v=%0b i=%0d q=%0d, want v=%0b i=%0d q=%0d",
                         k, out_valid, out_i, out_q, m_v, m_out_i, m_out_q);
            end
        end
        for (int k = 0; k < 20; k++) begin
            step(1, 500, 16384, -16384, 4, 0);
            vectors++;
            if ({out_valid, overflow, out_i, out_q} !==
                {m_v, m_ov, m_out_i[OW-1:0], m_out_q[OW-1:0]}) begin
                errors++;
                $display("FAIL clear_after[%0d]: got v=%0b i=%0d q=%0d, want v=%0b i=%0d q=%0d",
                         k, out_valid, out_i, out_q, m_v, m_out_i, m_out_q);
            end
            if (k == 16 + LAT) begin
                vectors++;
                if (!(out_valid === 1'b1 && out_i === OW'(AVG ? 32000 : 128000)
                      && out_q === OW'(AVG ? -32000 : -128000))) begin
                    errors++;
                    $display("FAIL clear_strobe: got v=%0b i=%0d q=%0d, want v=1 i=%0d q=%0d",
                             out_valid, out_i, out_q, AVG ? 32000 : 128000,
                             AVG ? -32000 : -128000);
                end
            end
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            step(k < 6, -8192, -32768, 32767, 0, 0);
            vectors++;
            if ({out_valid, overflow, out_i, out_q} !==
                {m_v, m_ov, m_out_i[OW-1:0], m_out_q[OW-1:0]}) begin
                errors++;
                $display("FAIL sat_main[%0d]: got v=%0b i=%0d q=%0d, want v=%0b i=%0d q=%0d",
                         k, out_valid, out_i, out_q, m_v, m_out_i, m_out_q);
            end
        end
        vectors++;
        if ({sat_overflow, sat_out_i, sat_out_q} !== {1'b1, 24'sd8388607, -24'sd8388608}) begin
            errors++;
            $display("FAIL saturate: got ov=%0b i=%0d q=%0d, want ov=1 i=8388607 q=-8388608",
                     sat_overflow, sat_out_i, sat_out_q);
        end
        step(0, 0, 0, 0, 0, 1);
        vectors++;
        if ({sat_overflow, sat_out_valid, sat_out_i} !== {1'b0, 1'b0, 24'sd8388607}) begin
            errors++;
            $display("FAIL sat_clear: got ov=%0b v=%0b i=%0d, want ov=0 v=0 i=8388607",
                     sat_overflow, sat_out_valid, sat_out_i);
        end
    endtask

    task automatic test_reset_async();
        for (int k = 0; k < 8; k++) step(1, 700, 16384, 0, 4, 0);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, overflow, out_i, out_q} !== {1'b0, 1'b0, 48'd0}) begin
            errors++;
            $display("FAIL async_reset: got v=%0b ov=%0b i=%0d q=%0d, want all zero",
                     out_valid, overflow, out_i, out_q);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            step(1, 700, 16384, 0, 4, 0);
            vectors++;
            if ({out_valid, overflow, out_i, out_q} !==
                {m_v, m_ov, m_out_i[OW-1:0], m_out_q[OW-1:0]}) begin
                errors++;
                $display("FAIL post_reset[%0d]: got v=%0b i=%0d, want v=%0b i=%0d",
                         k, out_valid, out_i, m_v, m_out_i);
            end
            if (k == 16 + LAT) begin
                vectors++;
                if (!(out_valid === 1'b1 && out_i === OW'(AVG ? 44800 : 179200))) begin
                    errors++;
                    $display("FAIL post_reset_strobe: got v=%0b i=%0d, want v=1 i=%0d",
                             out_valid, out_i, AVG ? 44800 : 179200);
                end
            end
        end
    endtask

    task automatic test_random();
        int w = 2;
        for (int k = 0; k < 600; k++) begin
            if (k % 37 == 0) w = $urandom_range(0, 4);
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 w, $urandom_range(0, 99) == 0);
            vectors++;
            if ({out_valid, overflow, out_i, out_q} !==
                {m_v, m_ov, m_out_i[OW-1:0], m_out_q[OW-1:0]}) begin
                errors++;
                $display("FAIL random[%0d]: got v=%0b ov=%0b i=%0d q=%0d, want v=%0b ov=%0b i=%0d q=%0d",
                         k, out_valid, overflow, out_i, out_q, m_v, m_ov, m_out_i, m_out_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_clear_mid();
        test_saturation();
        test_reset_async();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
